// File: rtl/ucsbece154b_icache.sv
// ucsbece154b_icache: 4-way set-associative instruction cache with
// critical-word-first block refill from a cache controller.
// Optional feature macro: ICACHE_EARLY_RESTART_EN -- when defined, the
// critical word is forwarded to the core during fill beat 0.
module ucsbece154b_icache #(
  parameter int NUM_SETS   = 8,
  parameter int BLOCK_SIZE = 4,
  parameter int NUM_WAYS   = 4
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        ReadEnable_i,
  input  logic [31:0] Address_i,
  output logic [31:0] Instr_o,
  output logic        Busy_o,
  output logic        ReadRequest_o,
  output logic [31:0] ReadAddress_o,
  input  logic [31:0] Datain_i,
  input  logic        Dataready_i
);

  localparam int OFF_W = $clog2(BLOCK_SIZE);
  localparam int SET_W = $clog2(NUM_SETS);
  localparam int TAG_W = 32 - SET_W - OFF_W - 2;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {IDLE, REQUEST, WAIT, FILL} state_t;

  state_t           r_state, w_next;
  logic [31:2]      r_addr;
  logic [OFF_W-1:0] r_beat;
  logic             r_valid [NUM_SETS][NUM_WAYS];
  logic [1:0]       r_rr    [NUM_SETS];
  logic [TAG_W-1:0] r_tag   [NUM_SETS][NUM_WAYS];
  logic [31:0]      r_data  [NUM_SETS][NUM_WAYS][BLOCK_SIZE];

  logic [TAG_W-1:0]    w_tag, w_ftag;
  logic [SET_W-1:0]    w_set, w_fset;
  logic [OFF_W-1:0]    w_off, w_crit, w_woff;
  logic                w_match, w_miss, w_we, w_done;
  logic [1:0]          w_hit_way, w_victim;
  logic [NUM_WAYS-1:0] w_fvalid;
  logic                w_unused;

  // Beat 0 carries the critical word; later beats walk the remaining offsets upward.
  function automatic logic [OFF_W-1:0] beat_to_off(input logic [OFF_W-1:0] beat,
                                                   input logic [OFF_W-1:0] crit);
    logic [OFF_W-1:0] prev;
    prev = beat - OFF_W'(1);
    if (beat == '0)       return crit;
    else if (prev < crit) return prev;
    else                  return beat;
  endfunction

  // Lowest-index invalid way, otherwise the set's round-robin pointer.
  function automatic logic [1:0] pick_victim(input logic [NUM_WAYS-1:0] valid,
                                             input logic [1:0] rr);
    logic [1:0] v;
    logic       found;
    v = rr;
    found = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!valid[w] && !found) begin
        v = 2'(w);
        found = 1'b1;
      end
    end
    return v;
  endfunction

  assign w_tag    = Address_i[31 -: TAG_W];
  assign w_set    = Address_i[SET_W+OFF_W+1 : OFF_W+2];
  assign w_off    = Address_i[OFF_W+1 : 2];
  assign w_ftag   = r_addr[31 -: TAG_W];
  assign w_fset   = r_addr[SET_W+OFF_W+1 : OFF_W+2];
  assign w_crit   = r_addr[OFF_W+1 : 2];
  assign w_woff   = beat_to_off(r_beat, w_crit);
  assign w_unused = ^Address_i[1:0];

  // Tag lookup across all ways of the indexed set, plus victim selection for the fill set.
  always_comb begin
    w_match   = 1'b0;
    w_hit_way = 2'd0;
    w_fvalid  = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      w_fvalid[w] = r_valid[w_fset][w];
      if (r_valid[w_set][w] && (r_tag[w_set][w] == w_tag)) begin
        w_match   = 1'b1;
        w_hit_way = 2'(w);
      end else begin
        w_match   = w_match;
      end
    end
    w_victim = pick_victim(w_fvalid, r_rr[w_fset]);
  end

  // Next-state logic and array write strobes.
  always_comb begin
    w_next = r_state;
    w_miss = 1'b0;
    w_we   = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (ReadEnable_i && !w_match) begin
          w_miss = 1'b1;
          w_next = REQUEST;
        end else begin
          w_next = IDLE;
        end
      end
      REQUEST: w_next = WAIT;
      WAIT: begin
        if (Dataready_i) begin
          w_we   = 1'b1;
          w_next = FILL;
        end else begin
          w_next = WAIT;
        end
      end
      FILL: begin
        if (Dataready_i) begin
          w_we = 1'b1;
          if (r_beat == LAST_BEAT) begin
            w_done = 1'b1;
            w_next = IDLE;
          end else begin
            w_next = FILL;
          end
        end else begin
          w_next = FILL;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Core- and controller-facing outputs; forced to zero while reset is held.
  always_comb begin
    Busy_o        = 1'b0;
    Instr_o       = 32'd0;
    ReadRequest_o = 1'b0;
    ReadAddress_o = 32'd0;
    if (reset_i) begin
      case (r_state)
        IDLE: begin
          Busy_o  = ReadEnable_i && !w_match;
          Instr_o = (ReadEnable_i && w_match) ? r_data[w_set][w_hit_way][w_off] : 32'd0;
        end
        REQUEST: begin
          Busy_o        = 1'b1;
          ReadRequest_o = 1'b1;
          ReadAddress_o = {r_addr, 2'b00};
        end
        WAIT: begin
`ifdef ICACHE_EARLY_RESTART_EN
          Busy_o  = !Dataready_i;
          Instr_o = Dataready_i ? Datain_i : 32'd0;
`else
          Busy_o  = 1'b1;
`endif
        end
        FILL:    Busy_o = 1'b1;
        default: Busy_o = 1'b0;
      endcase
    end else begin
      Busy_o = 1'b0;
    end
  end

  // Control state: FSM, latched miss address, beat counter, valid bits and round-robin pointers.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_beat  <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        r_rr[s] <= 2'd0;
        for (int w = 0; w < NUM_WAYS; w++) r_valid[s][w] <= 1'b0;
      end
    end else begin
      r_state <= w_next;
      if (w_miss) r_addr <= Address_i[31:2];
      if (w_we)   r_beat <= r_beat + OFF_W'(1);
      if (w_done) begin
        r_valid[w_fset][w_victim] <= 1'b1;
        r_rr[w_fset]              <= r_rr[w_fset] + 2'd1;
      end
    end
  end

  // Tag and data arrays carry no reset; validity alone decides whether they are used.
  always_ff @(posedge clk) begin
    if (w_we)   r_data[w_fset][w_victim][w_woff] <= Datain_i;
    if (w_done) r_tag[w_fset][w_victim]          <= w_ftag;
  end

endmodule

// File: tb/tb_ucsbece154b_icache.sv
// Testbench for ucsbece154b_icache (default parameters: 8 sets, 4 words, 4 ways).
module tb_ucsbece154b_icache;

  logic        clk;
  logic        reset_i;
  logic        ReadEnable_i;
  logic [31:0] Address_i;
  logic [31:0] Instr_o;
  logic        Busy_o;
  logic        ReadRequest_o;
  logic [31:0] ReadAddress_o;
  logic [31:0] Datain_i;
  logic        Dataready_i;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    logic        hit;
  } vec_t;
  vec_t tbl[27];

  ucsbece154b_icache dut (
    .clk(clk), .reset_i(reset_i), .ReadEnable_i(ReadEnable_i), .Address_i(Address_i),
    .Instr_o(Instr_o), .Busy_o(Busy_o), .ReadRequest_o(ReadRequest_o),
    .ReadAddress_o(ReadAddress_o), .Datain_i(Datain_i), .Dataready_i(Dataready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk1({name, "_busy"}, Busy_o, 1'b0);
    chk1({name, "_req"}, ReadRequest_o, 1'b0);
    chk({name, "_raddr"}, ReadAddress_o, 32'd0);
    chk({name, "_instr"}, Instr_o, 32'd0);
  endtask

  task automatic fetch_hit(input logic [31:0] a);
    @(negedge clk);
    ReadEnable_i = 1'b1;
    Address_i    = a;
    Dataready_i  = 1'b0;
    exp_q.push_back(mem_word(a));
    #1;
    chk1("hit_busy", Busy_o, 1'b0);
    chk("hit_instr", Instr_o, exp_q.pop_front());
  endtask

  task automatic miss_fill(input logic [31:0] a);
    logic [31:0] base;
    logic [1:0]  crit;
    logic [1:0]  order[4];
    int          n;
    base = {a[31:4], 4'h0};
    crit = a[3:2];
    order[0] = crit;
    n = 1;
    for (int o = 0; o < 4; o++) begin
      if (2'(o) != crit) begin
        order[n] = 2'(o);
        n++;
      end
    end
    // Miss detection cycle in IDLE.
    @(negedge clk);
    ReadEnable_i = 1'b1;
    Address_i    = a;
    Dataready_i  = 1'b0;
    #1;
    chk1("miss_busy", Busy_o, 1'b1);
    chk1("miss_noreq", ReadRequest_o, 1'b0);
    // REQUEST: the core wanders off to another address, which must be ignored.
    @(negedge clk);
    Address_i = a ^ 32'h0000_0F00;
    #1;
    chk1("req_pulse", ReadRequest_o, 1'b1);
    chk("req_addr", ReadAddress_o, {a[31:2], 2'b00});
    chk1("req_busy", Busy_o, 1'b1);
    // WAIT with no data yet.
    @(negedge clk);
    Address_i = a;
    #1;
    chk1("req_once", ReadRequest_o, 1'b0);
    chk1("wait_busy", Busy_o, 1'b1);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      Dataready_i = 1'b1;
      Datain_i    = mem_word(base + {28'd0, order[b], 2'b00});
      #1;
      chk1("fill_noreq", ReadRequest_o, 1'b0);
      if (b == 0) begin
`ifdef ICACHE_EARLY_RESTART_EN
        exp_q.push_back(Datain_i);
        chk1("beat0_busy", Busy_o, 1'b0);
        chk("beat0_instr", Instr_o, exp_q.pop_front());
`else
        chk1("beat0_busy", Busy_o, 1'b1);
`endif
      end else begin
        chk1("fill_busy", Busy_o, 1'b1);
      end
    end
    @(posedge clk);
    #1;
    Dataready_i  = 1'b0;
    ReadEnable_i = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{32'h0000_0008, 1'b0};
    tbl[1]  = '{32'h0000_0008, 1'b1};
    tbl[2]  = '{32'h0000_0000, 1'b1};
    tbl[3]  = '{32'h0000_0004, 1'b1};
    tbl[4]  = '{32'h0000_000C, 1'b1};
    tbl[5]  = '{32'h0000_0100, 1'b0};
    tbl[6]  = '{32'h0000_0100, 1'b1};
    tbl[7]  = '{32'h0000_0104, 1'b1};
    tbl[8]  = '{32'h0000_0108, 1'b1};
    tbl[9]  = '{32'h0000_010C, 1'b1};
    tbl[10] = '{32'h0000_0200, 1'b0};
    tbl[11] = '{32'h0000_0300, 1'b0};
    tbl[12] = '{32'h0000_0400, 1'b0};
    tbl[13] = '{32'h0000_0400, 1'b1};
    tbl[14] = '{32'h0000_0104, 1'b1};
    tbl[15] = '{32'h0000_0208, 1'b1};
    tbl[16] = '{32'h0000_030C, 1'b1};
    tbl[17] = '{32'h0000_0004, 1'b0};
    tbl[18] = '{32'h0000_0000, 1'b1};
    tbl[19] = '{32'h0000_0100, 1'b0};
    tbl[20] = '{32'h0000_030C, 1'b1};
    tbl[21] = '{32'h0000_0404, 1'b1};
    tbl[22] = '{32'h0000_0200, 1'b0};
    tbl[23] = '{32'h0000_1234, 1'b0};
    tbl[24] = '{32'h0000_1230, 1'b1};
    tbl[25] = '{32'h0000_123C, 1'b1};
    tbl[26] = '{32'h0000_0100, 1'b1};

    // Reset held with busy-looking inputs: every output must stay at zero.
    reset_i      = 1'b0;
    ReadEnable_i = 1'b1;
    Address_i    = 32'h0000_0008;
    Dataready_i  = 1'b1;
    Datain_i     = 32'hFFFF_FFFF;
    #1;
    chk_reset_outputs("rst0");
    @(posedge clk);
    #1;
    chk_reset_outputs("rst1");
    @(negedge clk);
    reset_i      = 1'b1;
    ReadEnable_i = 1'b0;
    Dataready_i  = 1'b0;

    // Table of lookups: misses run a full refill, hits compare the delivered word.
    for (int i = 0; i < 27; i++) begin
      if (tbl[i].hit) fetch_hit(tbl[i].addr);
      else            miss_fill(tbl[i].addr);
    end

    // A stray Dataready_i in IDLE must not write anything.
    @(negedge clk);
    ReadEnable_i = 1'b0;
    Address_i    = 32'h0000_2000;
    Dataready_i  = 1'b1;
    Datain_i     = mem_word(32'h0000_2000);
    #1;
    chk1("stray_busy", Busy_o, 1'b0);
    chk1("stray_req", ReadRequest_o, 1'b0);
    @(negedge clk);
    Dataready_i = 1'b0;
    miss_fill(32'h0000_2000);
    fetch_hit(32'h0000_2000);

    // Reset arriving at fill beat 2 discards the partial line.
    @(negedge clk);
    ReadEnable_i = 1'b1;
    Address_i    = 32'h0000_3008;
    @(negedge clk);
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      Dataready_i = 1'b1;
      Datain_i    = 32'hDEAD_0000 + 32'(b);
    end
    @(negedge clk);
    Datain_i = 32'hDEAD_0002;
    reset_i  = 1'b0;
    #1;
    chk_reset_outputs("midfill_rst");
    @(negedge clk);
    reset_i      = 1'b1;
    Dataready_i  = 1'b0;
    ReadEnable_i = 1'b0;
    miss_fill(32'h0000_3008);
    fetch_hit(32'h0000_3008);
    fetch_hit(32'h0000_3000);
    // Lines filled before the reset are gone as well.
    miss_fill(32'h0000_0008);
    fetch_hit(32'h0000_0008);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
